// File: rtl/z80_bus_cycle.sv
// z80_bus_cycle: Z80 machine-cycle sequencer (M1/mem/IO T-states, wait states, bus request).
// Every pin is a flop loaded from a decode of the next state.
module z80_bus_cycle (
    input  logic        CLK,
    input  logic        n_RESET,
    input  logic        cyc_req,
    input  logic [1:0]  cyc_type,
    input  logic        cyc_wr,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [15:0] rfsh_addr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] A,
    output logic        A_oe,
    output logic [7:0]  D_out,
    input  logic [7:0]  D_in,
    output logic        D_oe,
    output logic        n_M1,
    output logic        n_MREQ,
    output logic        n_IORQ,
    output logic        n_RD,
    output logic        n_WR,
    output logic        n_RFSH,
    output logic        ctl_oe,
    input  logic        n_WAIT,
    input  logic        n_BUSREQ,
    output logic        n_BUSACK
);
    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4, BUSAK} state_t;
    state_t state_q, state_d;
    logic [1:0] type_q, type_d;
    logic wr_q, wr_d;
    logic [15:0] addr_q, addr_d, a_q, a_d;
    logic [7:0] wdata_q, wdata_d, dout_q, dout_d, rdata_q, rdata_d;
    logic busy_q, busy_d, done_q, done_d, oe_q, oe_d, doe_q, doe_d, busack_q, busack_d;
    logic n_m1_q, n_m1_d, n_mreq_q, n_mreq_d, n_iorq_q, n_iorq_d;
    logic n_rd_q, n_rd_d, n_wr_q, n_wr_d, n_rfsh_q, n_rfsh_d;
    logic m1, mrd, mwr, io, iow, act, mid, early, rf, cap;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (!n_BUSREQ) begin
                    state_d = BUSAK;
                end else if (cyc_req) begin
                    state_d = T1;
                    type_d  = cyc_type;
                    wr_d    = cyc_wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            T1:      state_d = T2;
            // IO always inserts one wait state before n_WAIT is honoured
            T2:      state_d = (type_q == 2'b11 || !n_WAIT) ? TW : T3;
            TW:      state_d = n_WAIT ? T3 : TW;
            T3:      state_d = (type_q == 2'b00) ? T4 : IDLE;
            T4:      state_d = IDLE;
            BUSAK:   state_d = n_BUSREQ ? IDLE : BUSAK;
            default: state_d = IDLE;
        endcase
        m1    = type_d == 2'b00;
        mrd   = type_d == 2'b01;
        mwr   = type_d == 2'b10;
        io    = type_d == 2'b11;
        iow   = io && wr_d;
        act   = state_d inside {T1, T2, TW, T3};
        mid   = state_d inside {T2, TW, T3};
        early = state_d inside {T1, T2, TW};
        rf    = m1 && state_d inside {T3, T4};
        n_m1_d   = !(m1 && early);
        n_mreq_d = !(((mrd || mwr) && act) || (m1 && (early || state_d == T4)));
        n_iorq_d = !(io && mid);
        n_rd_d   = !((mrd && act) || (io && !wr_d && mid) || (m1 && early));
        n_wr_d   = !((mwr || iow) && mid);
        n_rfsh_d = !rf;
        doe_d    = (mwr || iow) && act;
        dout_d   = doe_d ? wdata_d : 8'h00;
        a_d      = rf ? rfsh_addr : (act ? addr_d : 16'h0000);
        oe_d     = state_d != BUSAK;
        busack_d = state_d != BUSAK;
        busy_d   = state_d != IDLE;
        done_d   = (state_q == T3 && type_q != 2'b00) || state_q == T4;
        // opcode is taken at the end of the data phase, before refresh
        cap      = (state_q == T3 && (type_q == 2'b01 || (type_q == 2'b11 && !wr_q))) ||
                   (type_q == 2'b00 && state_q inside {T2, TW} && state_d == T3);
        rdata_d  = cap ? D_in : rdata_q;
    end

    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            state_q  <= IDLE;
            type_q   <= 2'b00;
            wr_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            a_q      <= 16'h0000;
            dout_q   <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oe_q     <= 1'b1;
            doe_q    <= 1'b0;
            busack_q <= 1'b1;
            n_m1_q   <= 1'b1;
            n_mreq_q <= 1'b1;
            n_iorq_q <= 1'b1;
            n_rd_q   <= 1'b1;
            n_wr_q   <= 1'b1;
            n_rfsh_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            a_q      <= a_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            oe_q     <= oe_d;
            doe_q    <= doe_d;
            busack_q <= busack_d;
            n_m1_q   <= n_m1_d;
            n_mreq_q <= n_mreq_d;
            n_iorq_q <= n_iorq_d;
            n_rd_q   <= n_rd_d;
            n_wr_q   <= n_wr_d;
            n_rfsh_q <= n_rfsh_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign A        = a_q;
    assign A_oe     = oe_q;
    assign ctl_oe   = oe_q;
    assign D_out    = dout_q;
    assign D_oe     = doe_q;
    assign n_BUSACK = busack_q;
    assign n_M1     = n_m1_q;
    assign n_MREQ   = n_mreq_q;
    assign n_IORQ   = n_iorq_q;
    assign n_RD     = n_rd_q;
    assign n_WR     = n_wr_q;
    assign n_RFSH   = n_rfsh_q;
endmodule

// File: tb/tb_z80_bus_cycle.sv
// tb_z80_bus_cycle: per-cycle vector table for the main cycle types plus reset/wait corner cases.
module tb_z80_bus_cycle;
    logic CLK = 1'b0, n_RESET = 1'b1, cyc_req = 1'b0, cyc_wr = 1'b0, n_WAIT = 1'b1, n_BUSREQ = 1'b1;
    logic [1:0] cyc_type = 2'b00;
    logic [15:0] addr = 16'h0, rfsh_addr = 16'h3F7E, A;
    logic [7:0] wdata = 8'h0, D_in = 8'h0, rdata, D_out;
    logic busy, done, A_oe, D_oe, n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH, ctl_oe, n_BUSACK;
    int tests = 0, fails = 0;

    localparam logic [5:0] I = 6'b111111;
    localparam logic [15:0] RF = 16'h3F7E;

    typedef struct {
        logic req; logic [1:0] ty; logic wr; logic [15:0] ad; logic [7:0] wd;
        logic [7:0] din; logic wt; logic br; logic [43:0] exp;
    } vec_t;
    vec_t v [25];

    z80_bus_cycle dut (
        .CLK(CLK), .n_RESET(n_RESET), .cyc_req(cyc_req), .cyc_type(cyc_type), .cyc_wr(cyc_wr),
        .addr(addr), .wdata(wdata), .rfsh_addr(rfsh_addr), .busy(busy), .done(done), .rdata(rdata),
        .A(A), .A_oe(A_oe), .D_out(D_out), .D_in(D_in), .D_oe(D_oe), .n_M1(n_M1), .n_MREQ(n_MREQ),
        .n_IORQ(n_IORQ), .n_RD(n_RD), .n_WR(n_WR), .n_RFSH(n_RFSH), .ctl_oe(ctl_oe),
        .n_WAIT(n_WAIT), .n_BUSREQ(n_BUSREQ), .n_BUSACK(n_BUSACK)
    );

    always #5 CLK = ~CLK;

    // {busy,done,n_BUSACK,A_oe,ctl_oe,D_oe,{n_M1,n_MREQ,n_IORQ,n_RD,n_WR,n_RFSH},A,D_out,rdata}
    function automatic logic [43:0] ex(logic bsy, logic dn, logic bk, logic oe, logic doe,
                                       logic [5:0] s, logic [15:0] a, logic [7:0] dout, logic [7:0] rd);
        return {bsy, dn, bk, oe, oe, doe, s, a, dout, rd};
    endfunction

    function automatic vec_t mk(logic req, logic [1:0] ty, logic wr, logic [15:0] ad, logic [7:0] wd,
                                logic [7:0] din, logic wt, logic br, logic [43:0] e);
        vec_t r;
        r.req = req; r.ty = ty; r.wr = wr; r.ad = ad; r.wd = wd;
        r.din = din; r.wt = wt; r.br = br; r.exp = e;
        return r;
    endfunction

    function automatic logic [43:0] obs();
        return {busy, done, n_BUSACK, A_oe, ctl_oe, D_oe, n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH,
                A, D_out, rdata};
    endfunction

    task automatic check(string name, logic [43:0] got, logic [43:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(logic req, logic [1:0] ty, logic wr, logic [15:0] ad, logic [7:0] wd,
                         logic [7:0] din, logic wt, logic br);
        cyc_req = req; cyc_type = ty; cyc_wr = wr; addr = ad; wdata = wd;
        D_in = din; n_WAIT = wt; n_BUSREQ = br;
    endtask

    initial begin
        // mem read 0x1234, requests while busy must be ignored
        v[0]  = mk(1, 2'd1, 0, 16'h1234, 8'h00, 8'hA5, 1, 1, ex(1, 0, 1, 1, 0, 6'b101011, 16'h1234, 8'h00, 8'h00));
        v[1]  = mk(1, 2'd2, 0, 16'hFFFF, 8'hEE, 8'hA5, 1, 1, ex(1, 0, 1, 1, 0, 6'b101011, 16'h1234, 8'h00, 8'h00));
        v[2]  = mk(1, 2'd2, 0, 16'hFFFF, 8'hEE, 8'hA5, 1, 1, ex(1, 0, 1, 1, 0, 6'b101011, 16'h1234, 8'h00, 8'h00));
        v[3]  = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'hA5, 1, 1, ex(0, 1, 1, 1, 0, I, 16'h0000, 8'h00, 8'hA5));
        // M1 0x0100 with two wait states, opcode 0x3C
        v[4]  = mk(1, 2'd0, 0, 16'h0100, 8'h00, 8'h11, 1, 1, ex(1, 0, 1, 1, 0, 6'b001011, 16'h0100, 8'h00, 8'hA5));
        v[5]  = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h11, 1, 1, ex(1, 0, 1, 1, 0, 6'b001011, 16'h0100, 8'h00, 8'hA5));
        v[6]  = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h11, 0, 1, ex(1, 0, 1, 1, 0, 6'b001011, 16'h0100, 8'h00, 8'hA5));
        v[7]  = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h11, 0, 1, ex(1, 0, 1, 1, 0, 6'b001011, 16'h0100, 8'h00, 8'hA5));
        v[8]  = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h3C, 1, 1, ex(1, 0, 1, 1, 0, 6'b111110, RF, 8'h00, 8'h3C));
        v[9]  = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(1, 0, 1, 1, 0, 6'b101110, RF, 8'h00, 8'h3C));
        v[10] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(0, 1, 1, 1, 0, I, 16'h0000, 8'h00, 8'h3C));
        // IO write 0x00FE/0x5A, exactly one forced TW
        v[11] = mk(1, 2'd3, 1, 16'h00FE, 8'h5A, 8'h77, 1, 1, ex(1, 0, 1, 1, 1, I, 16'h00FE, 8'h5A, 8'h3C));
        v[12] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(1, 0, 1, 1, 1, 6'b110101, 16'h00FE, 8'h5A, 8'h3C));
        v[13] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(1, 0, 1, 1, 1, 6'b110101, 16'h00FE, 8'h5A, 8'h3C));
        v[14] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(1, 0, 1, 1, 1, 6'b110101, 16'h00FE, 8'h5A, 8'h3C));
        v[15] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(0, 1, 1, 1, 0, I, 16'h0000, 8'h00, 8'h3C));
        // mem write with bus request arriving in T2
        v[16] = mk(1, 2'd2, 0, 16'h4000, 8'hC3, 8'h77, 1, 1, ex(1, 0, 1, 1, 1, 6'b101111, 16'h4000, 8'hC3, 8'h3C));
        v[17] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(1, 0, 1, 1, 1, 6'b101101, 16'h4000, 8'hC3, 8'h3C));
        v[18] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 0, ex(1, 0, 1, 1, 1, 6'b101101, 16'h4000, 8'hC3, 8'h3C));
        v[19] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 0, ex(0, 1, 1, 1, 0, I, 16'h0000, 8'h00, 8'h3C));
        v[20] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 0, ex(1, 0, 0, 0, 0, I, 16'h0000, 8'h00, 8'h3C));
        v[21] = mk(1, 2'd1, 0, 16'h2222, 8'h00, 8'h77, 1, 0, ex(1, 0, 0, 0, 0, I, 16'h0000, 8'h00, 8'h3C));
        v[22] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(0, 0, 1, 1, 0, I, 16'h0000, 8'h00, 8'h3C));
        // bus request beats a simultaneous cycle request
        v[23] = mk(1, 2'd1, 0, 16'h3333, 8'h00, 8'h77, 1, 0, ex(1, 0, 0, 0, 0, I, 16'h0000, 8'h00, 8'h3C));
        v[24] = mk(0, 2'd0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, ex(0, 0, 1, 1, 0, I, 16'h0000, 8'h00, 8'h3C));

        #2 n_RESET = 1'b0;
        #1 check("reset_state", obs(), ex(0, 0, 1, 1, 0, I, 16'h0000, 8'h00, 8'h00));
        @(negedge CLK);
        n_RESET = 1'b1;
        for (int i = 0; i < 25; i++) begin
            drive(v[i].req, v[i].ty, v[i].wr, v[i].ad, v[i].wd, v[i].din, v[i].wt, v[i].br);
            tick();
            check($sformatf("vec%0d", i), obs(), v[i].exp);
        end

        // IO read held in TW, then reset mid-cycle
        drive(1, 2'd3, 0, 16'h0042, 8'h00, 8'h55, 0, 1);
        tick();
        check("ioread_T1", obs(), ex(1, 0, 1, 1, 0, I, 16'h0042, 8'h00, 8'h3C));
        cyc_req = 1'b0;
        tick();
        check("ioread_T2", obs(), ex(1, 0, 1, 1, 0, 6'b110011, 16'h0042, 8'h00, 8'h3C));
        for (int i = 0; i < 20; i++) tick();
        check("ioread_long_TW", obs(), ex(1, 0, 1, 1, 0, 6'b110011, 16'h0042, 8'h00, 8'h3C));
        n_RESET = 1'b0;
        #1 check("reset_mid_TW", obs(), ex(0, 0, 1, 1, 0, I, 16'h0000, 8'h00, 8'h00));
        @(negedge CLK);
        n_RESET = 1'b1;
        drive(1, 2'd1, 0, 16'h5555, 8'h00, 8'h99, 1, 1);
        tick();
        check("post_reset_T1", obs(), ex(1, 0, 1, 1, 0, 6'b101011, 16'h5555, 8'h00, 8'h00));
        cyc_req = 1'b0;
        tick();
        tick();
        tick();
        check("post_reset_done", obs(), ex(0, 1, 1, 1, 0, I, 16'h0000, 8'h00, 8'h99));
        tick();
        check("done_one_cycle", obs(), ex(0, 0, 1, 1, 0, I, 16'h0000, 8'h00, 8'h99));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/z80_bus_cycle.md
Z80_BUS_CYCLE -- requirements
Module: z80_bus_cycle

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on rising edge.
REQ-002 SHALL have port n_RESET, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have cyc_req, input, 1: core requests a machine cycle.
REQ-004 SHALL have cyc_type, input, 2: 00 M1 fetch, 01 mem read, 10 mem write, 11 IO.
REQ-005 SHALL have cyc_wr, input, 1: IO direction (1 write, 0 read); ignored for other types.
REQ-006 SHALL have addr, input, 16, and wdata, input, 8: cycle address and write data.
REQ-007 SHALL have rfsh_addr, input, 16: {I,R} refresh address.
REQ-008 SHALL have busy, output, 1: high whenever not in IDLE.
REQ-009 SHALL have done, output, 1: one-cycle pulse at cycle completion; rdata, output, 8: captured read/opcode byte.
REQ-010 SHALL have A, output, 16; A_oe, output, 1; D_out, output, 8; D_in, input, 8; D_oe, output, 1.
REQ-011 SHALL have n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH, outputs, 1 each, active-low strobes; ctl_oe, output, 1.
REQ-012 SHALL have n_WAIT, input, 1; n_BUSREQ, input, 1; n_BUSACK, output, 1.

Function
REQ-013 SHALL implement states IDLE, T1, T2, TW, T3, T4, BUSAK; all outputs registered.
REQ-014 In IDLE, n_BUSREQ=0 SHALL move to BUSAK, taking priority over a simultaneous cyc_req.
REQ-015 In IDLE, cyc_req=1 with n_BUSREQ=1 SHALL latch cyc_type, cyc_wr, addr, wdata and move to T1; requests while busy SHALL be ignored.
REQ-016 T1 SHALL move to T2; A SHALL carry latched addr from T1 until cycle end.
REQ-017 From T2 or TW, n_WAIT sampled 0 SHALL go to TW, 1 SHALL go to T3; for IO, T2 SHALL always go to one forced TW before n_WAIT is evaluated.
REQ-018 Mem read: n_MREQ=n_RD=0 in T1, T2, TW, T3; rdata SHALL capture D_in on the edge leaving T3.
REQ-019 Mem write: n_MREQ=0 in T1..T3; n_WR=0 in T2, TW, T3; D_oe=1 with D_out=wdata in T1..T3.
REQ-020 IO: n_IORQ=0 and n_RD (read) or n_WR (write) =0 in T2, TW, T3; D_oe=1 T1..T3 for IO write.
REQ-021 M1: n_M1=n_MREQ=n_RD=0 in T1, T2, TW; rdata SHALL capture D_in on edge leaving T2/last TW; T3 SHALL go to T4.
REQ-022 M1 T3 and T4: A=rfsh_addr, n_RFSH=0; n_MREQ=0 in T4 only; n_M1, n_RD high.
REQ-023 done SHALL pulse high in the cycle after the final T-state (T3, or T4 for M1), with state back in IDLE.
REQ-024 BUSAK: n_BUSACK=0, A_oe=D_oe=ctl_oe=0; return to IDLE the cycle after n_BUSREQ sampled 1; n_BUSREQ SHALL NOT abort an active cycle.
REQ-025 Outside REQ-018..022, all strobes SHALL be 1; A_oe=ctl_oe=1 outside BUSAK.
REQ-026 TW count SHALL be unbounded while n_WAIT=0.

Reset
REQ-027 n_RESET=0 SHALL immediately force IDLE, all strobes 1, n_BUSACK=1, A=0, A_oe=ctl_oe=1, D_oe=0, D_out=0, rdata=0, done=0, busy=0, including mid-cycle.
REQ-028 After n_RESET release, first cycle SHALL be accepted on the first rising edge with cyc_req=1.

Verification
REQ-029 Mem read addr=0x1234, D_in=0xA5, n_WAIT=1 -> T1,T2,T3, n_RD low 3 cycles, done next cycle, rdata=0xA5.
REQ-030 M1 addr=0x0100, rfsh_addr=0x3F7E, n_WAIT=0 for 2 samples -> T1,T2,TW,TW,T3,T4; A=0x3F7E with n_RFSH=0 in T3,T4.
REQ-031 IO write addr=0x00FE, wdata=0x5A, n_WAIT=1 -> exactly one TW; n_IORQ=n_WR=0 in T2,TW,T3; D_oe=1 T1..T3.
REQ-032 n_BUSREQ=0 asserted during mem write T2 -> write completes, done pulses, then BUSAK with n_BUSACK=0, A_oe=0; release -> IDLE.
REQ-033 n_RESET=0 in TW of IO read -> strobes high same cycle, busy=0, rdata=0; next cyc_req accepted normally.
